// File: rtl/sample_feeder_pkg.sv
// -----------------------------------------------------------------------------
// sample_feeder_pkg
//   Shared definitions for the sample_feeder pacing stage:
//     - state_t       : FSM state encodings (IDLE / STROBE / GAP)
//     - DEFAULT_DEPTH : default FIFO depth of the feeder
//     - DEFAULT_PTR_W : pointer width matching DEFAULT_DEPTH
//     - DROP_CNT_W    : width of the optional rejected-word counter
//     - ptr_width()   : pointer width for an arbitrary power-of-two depth
//     - cnt_width()   : width of a down-counter holding values 0..max(a,b)-1
// -----------------------------------------------------------------------------
package sample_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        GAP    = 2'd2
    } state_t;

    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_PTR_W = $clog2(DEFAULT_DEPTH);
    localparam int DROP_CNT_W    = 16;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // The pacing counter is reloaded with (cycles - 1), so it never has to
    // hold the value max(a,b) itself.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// -----------------------------------------------------------------------------
// sample_fifo
//   DEPTH x WIDTH synchronous FIFO with a registered occupancy count.
//   Pointers are PTR_W bits and wrap naturally modulo DEPTH (DEPTH must be a
//   power of two). The read port is combinational from the head entry.
//
// Ports
//   clk      in   1          rising-edge clock
//   rst_n    in   1          asynchronous active-low reset (pointers, count)
//   push     in   1          write request; ignored while full
//   pop      in   1          read request; ignored while empty
//   wr_data  in   WIDTH      word written on push
//   rd_data  out  WIDTH      current head word
//   full     out  1          count == DEPTH
//   empty    out  1          count == 0
//   level    out  PTR_W+1    current occupancy
// -----------------------------------------------------------------------------
module sample_fifo
    import sample_feeder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int PTR_W = DEFAULT_PTR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   level
);

    localparam logic [PTR_W:0] DEPTH_L = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push_ok;
    logic             pop_ok;

    // Flags come from the registered count only, so a pop on the same edge
    // never opens room for a push into a full FIFO.
    assign full    = (count == DEPTH_L);
    assign empty   = (count == '0);
    assign level   = count;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only; it needs no reset because nothing reads an
    // entry before it has been written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/sample_feeder.sv
// -----------------------------------------------------------------------------
// sample_feeder
//   Upstream pacing stage: buffers IN_W-bit sample words in a small FIFO and
//   presents each one, truncated to its low OUT_W bits, on out_data with a
//   data_ready strobe of STROBE_CYCLES cycles, followed by an idle gap of
//   GAP_CYCLES cycles before the next sample may be popped.
//
// Optional feature (compile-time macro SAMPLE_FEEDER_DROP_CNT_EN):
//   defined     -> drop_cnt port present; counts words offered while full,
//                  saturating at 16'hFFFF
//   not defined -> no drop_cnt port or counter; rejected words are ignored
//
// Ports
//   CLOCK_50    in   1                 single clock, rising edge
//   rst_n       in   1                 asynchronous active-low reset
//   run         in   1                 1 = pop and emit; 0 = halt in IDLE
//   in_valid    in   1                 upstream word valid
//   in_data     in   IN_W              upstream word
//   in_ready    out  1                 FIFO not full
//   data_ready  out  1                 per-sample strobe to downstream
//   out_data    out  OUT_W             current sample, held until next pop
//   busy        out  1                 FSM not in IDLE
//   fifo_level  out  $clog2(DEPTH)+1   FIFO occupancy
//   drop_cnt    out  16                (macro only) words rejected while full
// -----------------------------------------------------------------------------
module sample_feeder
    import sample_feeder_pkg::*;
#(
    parameter int IN_W          = 16,
    parameter int OUT_W         = 8,
    parameter int DEPTH         = DEFAULT_DEPTH,
    parameter int STROBE_CYCLES = 1,
    parameter int GAP_CYCLES    = 500
) (
    input  logic                   CLOCK_50,
    input  logic                   rst_n,
    input  logic                   run,
    input  logic                   in_valid,
    input  logic [IN_W-1:0]        in_data,
    output logic                   in_ready,
    output logic                   data_ready,
    output logic [OUT_W-1:0]       out_data,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_level
`ifdef SAMPLE_FEEDER_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0]  drop_cnt
`endif
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = cnt_width(STROBE_CYCLES, GAP_CYCLES);

    localparam logic [CW-1:0] STROBE_LOAD = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD    = CW'(GAP_CYCLES - 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            fifo_full;
    logic            fifo_empty;
    logic [IN_W-1:0] head;
    logic            push;
    logic            pop;

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;

    // run is only looked at here, so dropping it mid-sample lets the current
    // strobe and gap finish before the FSM parks in IDLE.
    assign pop = (state == IDLE) && run && !fifo_empty;

    sample_fifo #(
        .WIDTH (IN_W),
        .DEPTH (DEPTH),
        .PTR_W (PW)
    ) u_fifo (
        .clk     (CLOCK_50),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .wr_data (in_data),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Upper word bits are discarded by design; no overflow flag exists.
    generate
        if (OUT_W < IN_W) begin : g_trunc
            logic unused_hi;
            assign unused_hi = ^head[IN_W-1:OUT_W];
        end
    endgenerate

    // The single pacing counter is reloaded with (cycles - 1) on every state
    // entry and the state is left on the cycle it reads zero, giving exactly
    // STROBE_CYCLES high and GAP_CYCLES low; the IDLE pop cycle adds one more,
    // so strobes are at least STROBE_CYCLES + GAP_CYCLES + 1 cycles apart.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            data_ready <= 1'b0;
            out_data   <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        out_data   <= head[OUT_W-1:0];
                        data_ready <= 1'b1;
                        busy       <= 1'b1;
                        cnt        <= STROBE_LOAD;
                        state      <= STROBE;
                    end
                end
                STROBE: begin
                    if (cnt == '0) begin
                        data_ready <= 1'b0;
                        cnt        <= GAP_LOAD;
                        state      <= GAP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    data_ready <= 1'b0;
                    busy       <= 1'b0;
                    cnt        <= '0;
                    state      <= IDLE;
                end
            endcase
        end
    end

`ifdef SAMPLE_FEEDER_DROP_CNT_EN
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (in_valid && !in_ready && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + DROP_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_sample_feeder.sv
// -----------------------------------------------------------------------------
// tb_sample_feeder
//   Directed bench for sample_feeder. Two instances share the input pins:
//   dut (default GAP_CYCLES = 500) and dut_g2 (GAP_CYCLES = 2), the latter
//   used for the FIFO wrap-around scenario. Outputs are sampled on the
//   falling edge; inputs are driven on the falling edge.
// -----------------------------------------------------------------------------
module tb_sample_feeder;

    logic        CLOCK_50 = 1'b0;
    logic        rst_n    = 1'b0;
    logic        run      = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data  = 16'h0000;

    logic        in_ready, data_ready, busy;
    logic [7:0]  out_data;
    logic [2:0]  fifo_level;
    logic        in_ready_g2, data_ready_g2, busy_g2;
    logic [7:0]  out_data_g2;
    logic [2:0]  fifo_level_g2;
`ifdef SAMPLE_FEEDER_DROP_CNT_EN
    logic [15:0] drop_cnt, drop_cnt_g2;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    sample_feeder dut (
        .CLOCK_50   (CLOCK_50),
        .rst_n      (rst_n),
        .run        (run),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .data_ready (data_ready),
        .out_data   (out_data),
        .busy       (busy),
        .fifo_level (fifo_level)
`ifdef SAMPLE_FEEDER_DROP_CNT_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    sample_feeder #(.GAP_CYCLES(2)) dut_g2 (
        .CLOCK_50   (CLOCK_50),
        .rst_n      (rst_n),
        .run        (run),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready_g2),
        .data_ready (data_ready_g2),
        .out_data   (out_data_g2),
        .busy       (busy_g2),
        .fifo_level (fifo_level_g2)
`ifdef SAMPLE_FEEDER_DROP_CNT_EN
        ,
        .drop_cnt   (drop_cnt_g2)
`endif
    );

    // Strobe log: cycle and data of every data_ready rising edge, plus the
    // high-time of every completed strobe (main instance only).
    int         cyc = 0;
    int         rise_cyc[$];
    logic [7:0] rise_dat[$];
    int         widths[$];
    int         rise_cyc_g2[$];
    logic [7:0] rise_dat_g2[$];
    logic       dr_prev = 1'b0;
    logic       dr_prev_g2 = 1'b0;
    int         hi_len = 0;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    always @(negedge CLOCK_50) begin
        if (data_ready && !dr_prev) begin
            rise_cyc.push_back(cyc);
            rise_dat.push_back(out_data);
        end
        if (data_ready) hi_len = hi_len + 1;
        else if (dr_prev) begin
            widths.push_back(hi_len);
            hi_len = 0;
        end
        dr_prev = data_ready;
        if (data_ready_g2 && !dr_prev_g2) begin
            rise_cyc_g2.push_back(cyc);
            rise_dat_g2.push_back(out_data_g2);
        end
        dr_prev_g2 = data_ready_g2;
    end

    task automatic clear_logs();
        rise_cyc.delete();
        rise_dat.delete();
        widths.delete();
        rise_cyc_g2.delete();
        rise_dat_g2.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0; in_valid = 1'b0; in_data = 16'h0000;
        repeat (3) @(negedge CLOCK_50);
        vectors++; if (data_ready !== 1'b0) begin miscompares++; $display("FAIL reset_data_ready: got %b want 0", data_ready); end
        vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        vectors++; if (fifo_level !== 3'd0) begin miscompares++; $display("FAIL reset_fifo_level: got %0d want 0", fifo_level); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
`ifdef SAMPLE_FEEDER_DROP_CNT_EN
        vectors++; if (drop_cnt !== 16'h0000) begin miscompares++; $display("FAIL reset_drop_cnt: got %h want 0000", drop_cnt); end
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge CLOCK_50);
    endtask

    task automatic test_single();
        int n;
        @(negedge CLOCK_50);
        run = 1'b1; in_valid = 1'b1; in_data = 16'hA55A;
        @(negedge CLOCK_50);                       // after accept edge k
        in_valid = 1'b0;
        vectors++; if (data_ready !== 1'b0) begin miscompares++; $display("FAIL single_early_strobe: got %b want 0", data_ready); end
        vectors++; if (fifo_level !== 3'd1) begin miscompares++; $display("FAIL single_level_after_push: got %0d want 1", fifo_level); end
        @(negedge CLOCK_50);                       // after edge k+1
        vectors++; if (data_ready !== 1'b1) begin miscompares++; $display("FAIL single_strobe: got %b want 1", data_ready); end
        vectors++; if (out_data !== 8'h5A) begin miscompares++; $display("FAIL single_out_data: got %h want 5a", out_data); end
        vectors++; if (fifo_level !== 3'd0) begin miscompares++; $display("FAIL single_level_after_pop: got %0d want 0", fifo_level); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b want 1", busy); end
        @(negedge CLOCK_50);                       // after edge k+2
        vectors++; if (data_ready !== 1'b0) begin miscompares++; $display("FAIL single_strobe_width: got %b want 0", data_ready); end
        vectors++; if (out_data !== 8'h5A) begin miscompares++; $display("FAIL single_out_hold: got %h want 5a", out_data); end
        n = 0;
        while (busy && n < 1000) begin @(negedge CLOCK_50); n++; end
        vectors++; if (n !== 500) begin miscompares++; $display("FAIL single_gap_length: got %0d want 500", n); end
    endtask

    task automatic test_burst();
        int n, acc;
        logic [7:0] got;
        clear_logs();
        @(negedge CLOCK_50);
        run = 1'b1; in_valid = 1'b1; in_data = 16'h0001;
        @(negedge CLOCK_50);
        acc = cyc; in_data = 16'h0002;
        @(negedge CLOCK_50);
        in_data = 16'h0003;
        @(negedge CLOCK_50);
        in_valid = 1'b0;
        n = 0;
        while (rise_cyc.size() < 3 && n < 1300) begin @(negedge CLOCK_50); n++; end
        vectors++; if (rise_cyc.size() !== 3) begin miscompares++; $display("FAIL burst_strobe_count: got %0d want 3", rise_cyc.size()); end
        if (rise_cyc.size() >= 3) begin
            vectors++; if (rise_cyc[0] - acc !== 1) begin miscompares++; $display("FAIL burst_latency: got %0d want 1", rise_cyc[0] - acc); end
            vectors++; if (rise_cyc[1] - rise_cyc[0] !== 502) begin miscompares++; $display("FAIL burst_spacing_1: got %0d want 502", rise_cyc[1] - rise_cyc[0]); end
            vectors++; if (rise_cyc[2] - rise_cyc[1] !== 502) begin miscompares++; $display("FAIL burst_spacing_2: got %0d want 502", rise_cyc[2] - rise_cyc[1]); end
        end
        for (int i = 0; i < 3; i++) begin
            got = (i < rise_dat.size()) ? rise_dat[i] : 8'hxx;
            vectors++; if (got !== 8'(i + 1)) begin miscompares++; $display("FAIL burst_data_%0d: got %h want %h", i, got, 8'(i + 1)); end
        end
        n = 0;
        while ((busy || fifo_level != 0) && n < 700) begin @(negedge CLOCK_50); n++; end
        vectors++; if (widths.size() !== 3) begin miscompares++; $display("FAIL burst_width_count: got %0d want 3", widths.size()); end
        foreach (widths[i]) begin
            vectors++; if (widths[i] !== 1) begin miscompares++; $display("FAIL burst_width_%0d: got %0d want 1", i, widths[i]); end
        end
    endtask

    task automatic test_full_drop();
        int n;
        logic [7:0] got;
        clear_logs();
        @(negedge CLOCK_50);
        run = 1'b0; in_valid = 1'b1; in_data = 16'h7F10;
        for (int i = 1; i < 4; i++) begin
            @(negedge CLOCK_50);
            in_data = 16'h7F10 + 16'(i);
        end
        @(negedge CLOCK_50);                       // four words accepted
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        vectors++; if (fifo_level !== 3'd4) begin miscompares++; $display("FAIL full_level: got %0d want 4", fifo_level); end
`ifdef SAMPLE_FEEDER_DROP_CNT_EN
        vectors++; if (drop_cnt !== 16'd0) begin miscompares++; $display("FAIL full_drop_before: got %0d want 0", drop_cnt); end
`endif
        in_data = 16'h7F14;                        // offered while full
        @(negedge CLOCK_50);
        in_valid = 1'b0;
        vectors++; if (fifo_level !== 3'd4) begin miscompares++; $display("FAIL full_level_after_drop: got %0d want 4", fifo_level); end
`ifdef SAMPLE_FEEDER_DROP_CNT_EN
        vectors++; if (drop_cnt !== 16'd1) begin miscompares++; $display("FAIL full_drop_cnt: got %0d want 1", drop_cnt); end
`endif
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL full_halted: got %b want 0", busy); end
        run = 1'b1;
        n = 0;
        while ((busy || fifo_level != 0 || rise_cyc.size() < 4) && n < 2200) begin @(negedge CLOCK_50); n++; end
        vectors++; if (rise_cyc.size() !== 4) begin miscompares++; $display("FAIL drain_count: got %0d want 4", rise_cyc.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < rise_dat.size()) ? rise_dat[i] : 8'hxx;
            vectors++; if (got !== 8'h10 + 8'(i)) begin miscompares++; $display("FAIL drain_data_%0d: got %h want %h", i, got, 8'h10 + 8'(i)); end
        end
        vectors++; if (fifo_level !== 3'd0) begin miscompares++; $display("FAIL drain_level: got %0d want 0", fifo_level); end
    endtask

    task automatic test_reset_gap();
        int n;
        @(negedge CLOCK_50);
        run = 1'b1; in_valid = 1'b1; in_data = 16'h1234;
        @(negedge CLOCK_50);
        in_data = 16'h5678;
        @(negedge CLOCK_50);
        in_valid = 1'b0;
        repeat (10) @(negedge CLOCK_50);           // well inside the gap
        vectors++; if (busy !== 1'b1 || data_ready !== 1'b0) begin miscompares++; $display("FAIL gap_state: got busy=%b dr=%b want busy=1 dr=0", busy, data_ready); end
        vectors++; if (fifo_level !== 3'd1) begin miscompares++; $display("FAIL gap_level: got %0d want 1", fifo_level); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (data_ready !== 1'b0) begin miscompares++; $display("FAIL async_rst_data_ready: got %b want 0", data_ready); end
        vectors++; if (fifo_level !== 3'd0) begin miscompares++; $display("FAIL async_rst_level: got %0d want 0", fifo_level); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL async_rst_busy: got %b want 0", busy); end
        vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL async_rst_out_data: got %h want 00", out_data); end
        @(negedge CLOCK_50);
        rst_n = 1'b1;
        @(negedge CLOCK_50);
        in_valid = 1'b1; in_data = 16'hBEC3;
        @(negedge CLOCK_50);
        in_valid = 1'b0;
        vectors++; if (data_ready !== 1'b0) begin miscompares++; $display("FAIL post_rst_early: got %b want 0", data_ready); end
        @(negedge CLOCK_50);
        vectors++; if (data_ready !== 1'b1 || out_data !== 8'hC3) begin miscompares++; $display("FAIL post_rst_sample: got dr=%b data=%h want dr=1 data=c3", data_ready, out_data); end
        n = 0;
        while (busy && n < 700) begin @(negedge CLOCK_50); n++; end
    endtask

    task automatic test_wrap_random();
        int i, n;
        logic saw_full;
        logic [7:0] got, exp;
        @(negedge CLOCK_50);
        rst_n = 1'b0; in_valid = 1'b0;
        @(negedge CLOCK_50);
        rst_n = 1'b1; run = 1'b1;
        clear_logs();
        i = 0; n = 0; saw_full = 1'b0;
        while (i < 10 && n < 400) begin
            @(negedge CLOCK_50);
            n++;
            if (!in_ready_g2) saw_full = 1'b1;
            if ($urandom_range(0, 2) != 0) begin
                in_valid = 1'b1;
                in_data  = 16'hF000 + 16'h0021 * 16'(i);
                if (in_ready_g2) i++;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge CLOCK_50);
        in_valid = 1'b0;
        vectors++; if (i !== 10) begin miscompares++; $display("FAIL wrap_all_accepted: got %0d want 10", i); end
        vectors++; if (saw_full !== 1'b1) begin miscompares++; $display("FAIL wrap_reached_full: got %b want 1", saw_full); end
        n = 0;
        while ((busy_g2 || fifo_level_g2 != 0) && n < 300) begin @(negedge CLOCK_50); n++; end
        vectors++; if (rise_dat_g2.size() !== 10) begin miscompares++; $display("FAIL wrap_count: got %0d want 10", rise_dat_g2.size()); end
        for (int k = 0; k < 10; k++) begin
            got = (k < rise_dat_g2.size()) ? rise_dat_g2[k] : 8'hxx;
            exp = 8'(16'h0021 * 16'(k));
            vectors++; if (got !== exp) begin miscompares++; $display("FAIL wrap_data_%0d: got %h want %h", k, got, exp); end
        end
        for (int k = 1; k < rise_cyc_g2.size(); k++) begin
            vectors++; if (rise_cyc_g2[k] - rise_cyc_g2[k-1] < 4) begin miscompares++; $display("FAIL wrap_spacing_%0d: got %0d want >=4", k, rise_cyc_g2[k] - rise_cyc_g2[k-1]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_full_drop();
        test_reset_gap();
        test_wrap_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
